// File: rtl/key_debounce_ctrl.sv
// Debounce controller: turns raw H2L/L2H edge pulses into clean press, release and
// long-press pulses plus a debounced key level, using a 1 ms timebase.
module key_debounce_ctrl #(
   parameter logic [15:0] T1MS        = 16'd49_999,
   parameter logic [9:0]  DEBOUNCE_MS = 10'd10,
   parameter logic [9:0]  LONG_MS     = 10'd1000
) (
   input  logic CLK,
   input  logic RSTn,
   input  logic H2L_Sig,
   input  logic L2H_Sig,
   output logic Key_Press,
   output logic Key_Release,
   output logic Key_Long,
   output logic Key_State
);

   typedef enum logic [1:0] {StIdle, StPressWait, StHeld, StReleaseWait} state_t;

   state_t      state_q, state_d;
   logic [15:0] presc_q, presc_d;
   logic [9:0]  ms_q, ms_d;
   logic        long_done_q, long_done_d;
   logic        press_q, press_d;
   logic        release_q, release_d;
   logic        long_q, long_d;
   logic        key_state_q, key_state_d;

   logic        ms_tick;
   logic [10:0] ms_next;
   logic        deb_hit;
   logic        long_hit;

   assign ms_tick  = (presc_q == T1MS);
   // 11-bit sum so the compare cannot wrap at 1023
   assign ms_next  = {1'b0, ms_q} + 11'd1;
   assign deb_hit  = ms_tick && (ms_next == {1'b0, DEBOUNCE_MS});
   assign long_hit = ms_tick && (ms_next == {1'b0, LONG_MS}) && !long_done_q;

   always_comb begin
      state_d     = state_q;
      presc_d     = ms_tick ? 16'd0 : presc_q + 16'd1;
      ms_d        = ms_q;
      long_done_d = long_done_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;
      key_state_d = key_state_q;

      case (state_q)
         StIdle: begin
            ms_d = 10'd0;
            if (H2L_Sig) state_d = StPressWait;
         end
         StPressWait: begin
            if (deb_hit) begin
               state_d     = StHeld;
               press_d     = 1'b1;
               key_state_d = 1'b1;
            end else if (ms_tick) begin
               ms_d = ms_next[9:0];
            end
         end
         StHeld: begin
            // Release takes priority over a coincident long-press tick
            if (L2H_Sig) begin
               state_d = StReleaseWait;
            end else begin
               if (ms_tick && (ms_q != LONG_MS)) ms_d = ms_next[9:0];
               if (long_hit) begin
                  long_d      = 1'b1;
                  long_done_d = 1'b1;
               end
            end
         end
         StReleaseWait: begin
            if (deb_hit) begin
               state_d     = StIdle;
               release_d   = 1'b1;
               key_state_d = 1'b0;
               long_done_d = 1'b0;
            end else if (ms_tick) begin
               ms_d = ms_next[9:0];
            end
         end
         default: state_d = StIdle;
      endcase

      // Restart the timebase on entry so the first ms in a state is a full ms
      if (state_d != state_q) begin
         presc_d = 16'd0;
         ms_d    = 10'd0;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q     <= StIdle;
         presc_q     <= 16'd0;
         ms_q        <= 10'd0;
         long_done_q <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
         key_state_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         ms_q        <= ms_d;
         long_done_q <= long_done_d;
         press_q     <= press_d;
         release_q   <= release_d;
         long_q      <= long_d;
         key_state_q <= key_state_d;
      end
   end

   assign Key_Press   = press_q;
   assign Key_Release = release_q;
   assign Key_Long    = long_q;
   assign Key_State   = key_state_q;

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// Directed bench for key_debounce_ctrl with a 10-cycle ms, 2 ms debounce, 5 ms long press.
module tb_key_debounce_ctrl;

   logic CLK = 1'b0;
   logic RSTn = 1'b0;
   logic H2L_Sig = 1'b0;
   logic L2H_Sig = 1'b0;
   logic Key_Press, Key_Release, Key_Long, Key_State;

   int tests = 0;
   int fails = 0;

   // Per-test schedule (cycle numbers, -1 = none)
   int h2l_at[4];
   int l2h_at[4];
   int rst_at, rst_len;
   int press_at, rel_at, long_at;
   string tag;

   key_debounce_ctrl #(
      .T1MS(16'd9),
      .DEBOUNCE_MS(10'd2),
      .LONG_MS(10'd5)
   ) dut (
      .CLK(CLK),
      .RSTn(RSTn),
      .H2L_Sig(H2L_Sig),
      .L2H_Sig(L2H_Sig),
      .Key_Press(Key_Press),
      .Key_Release(Key_Release),
      .Key_Long(Key_Long),
      .Key_State(Key_State)
   );

   always #5 CLK = ~CLK;

   function automatic logic in_list(input int c, input int l[4]);
      for (int i = 0; i < 4; i++) if (l[i] == c) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string name, input int c, input logic got, input logic exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s %s cycle=%0d got=%b exp=%b", tag, name, c, got, exp);
      end
   endtask

   task automatic clear_sched();
      for (int i = 0; i < 4; i++) begin
         h2l_at[i] = -1;
         l2h_at[i] = -1;
      end
      rst_at = -1; rst_len = 0;
      press_at = -1; rel_at = -1; long_at = -1;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RSTn = 1'b0; H2L_Sig = 1'b0; L2H_Sig = 1'b0;
      repeat (2) @(negedge CLK);
      RSTn = 1'b1;
   endtask

   // Cycle c: check registered outputs just after posedge c, then drive inputs for cycle c
   task automatic run(input int len);
      logic exp_state;
      for (int c = 0; c < len; c++) begin
         @(posedge CLK);
         #1;
         exp_state = (press_at >= 0) && (c >= press_at) && ((rel_at < 0) || (c < rel_at));
         chk("press", c, Key_Press, c == press_at);
         chk("release", c, Key_Release, c == rel_at);
         chk("long", c, Key_Long, c == long_at);
         chk("state", c, Key_State, exp_state);
         H2L_Sig = in_list(c, h2l_at);
         L2H_Sig = in_list(c, l2h_at);
         RSTn    = !((rst_at >= 0) && (c >= rst_at) && (c < rst_at + rst_len));
      end
      H2L_Sig = 1'b0;
      L2H_Sig = 1'b0;
      RSTn    = 1'b1;
   endtask

   initial begin
      // Reset values while RSTn is held low
      tag = "reset";
      #12;
      chk("press", 0, Key_Press, 1'b0);
      chk("release", 0, Key_Release, 1'b0);
      chk("long", 0, Key_Long, 1'b0);
      chk("state", 0, Key_State, 1'b0);

      tag = "clean_press";
      clear_sched();
      h2l_at[0] = 100; press_at = 121;
      do_reset(); run(165);

      tag = "bounce";
      clear_sched();
      h2l_at[0] = 100; l2h_at[0] = 105; h2l_at[1] = 110; l2h_at[1] = 115;
      press_at = 121; long_at = 171;
      do_reset(); run(200);

      tag = "long_press";
      clear_sched();
      h2l_at[0] = 100; press_at = 121; long_at = 171;
      do_reset(); run(380);

      tag = "short_press";
      clear_sched();
      h2l_at[0] = 100; l2h_at[0] = 140; press_at = 121; rel_at = 161;
      do_reset(); run(200);

      tag = "race";
      clear_sched();
      h2l_at[0] = 100; l2h_at[0] = 170; press_at = 121; rel_at = 191;
      do_reset(); run(260);

      tag = "mid_reset";
      clear_sched();
      h2l_at[0] = 100; h2l_at[1] = 200; rst_at = 110; rst_len = 3; press_at = 221;
      do_reset(); run(260);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/key_debounce_ctrl.md
Name: key_debounce_ctrl

Overview:
Sequencing controller that sits downstream of the key edge detector (H2L_Sig/L2H_Sig pulses) and turns raw, bouncy edge events into clean key events. It runs a debounce FSM with a 1 ms timebase. It locks out further edges for a debounce window after each transition. It reports press, release and long-press as single-cycle pulses plus a debounced level. Consumers (LED/menu logic) use only this block's outputs, never the raw edges.

Parameters:
T1MS, 16'd49_999, clock cycles per 1 ms minus 1 (50 MHz clock).
DEBOUNCE_MS, 10'd10, lockout window in ms after each accepted edge.
LONG_MS, 10'd1000, hold time in ms, measured from Key_Press, before Key_Long fires.

Ports:
CLK  input  1  system clock
RSTn  input  1  reset
H2L_Sig  input  1  1-cycle pulse from edge detector: key pressed (pin high-to-low)
L2H_Sig  input  1  1-cycle pulse from edge detector: key released (pin low-to-high)
Key_Press  output  1  1-cycle pulse: debounced press accepted
Key_Release  output  1  1-cycle pulse: debounced release accepted
Key_Long  output  1  1-cycle pulse: key held LONG_MS after Key_Press
Key_State  output  1  debounced level, 1 = pressed

Behaviour:
- Reset and clock: RSTn is asynchronous, active-low; CLK is the clock. All state is in CLK-domain flops.
- Reset values: FSM = IDLE, prescaler = 0, ms counter = 0, long_done = 0, all outputs 0.
- Timebase:
  - 16-bit prescaler counts 0..T1MS and wraps. ms_tick = (prescaler == T1MS).
  - Prescaler and 10-bit ms counter clear on every state transition, so the first ms after entry is a full ms.
  - ms counter increments on ms_tick.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
- IDLE:
  - H2L_Sig=1 -> PRESS_WAIT.
  - L2H_Sig ignored.
- PRESS_WAIT:
  - All edge inputs ignored (bounce lockout).
  - When ms counter reaches DEBOUNCE_MS (on the tick making it equal) -> HELD.
  - Key_Press=1 for that one cycle; Key_State goes 1 in the same cycle.
- HELD:
  - L2H_Sig=1 -> RELEASE_WAIT.
  - H2L_Sig ignored.
  - ms counter counts up and saturates at LONG_MS.
  - On the tick where the counter reaches LONG_MS and long_done=0: Key_Long=1 for one cycle, long_done <= 1. Fires at most once per press.
- RELEASE_WAIT:
  - Edges ignored.
  - When ms counter reaches DEBOUNCE_MS -> IDLE, Key_Release=1 for one cycle, Key_State <= 0, long_done <= 0.
- Outputs are registered and assert in the cycle the FSM enters the new state.
- Latency:
  - H2L_Sig high in cycle N -> state = PRESS_WAIT at N+1 -> Key_Press high at cycle N+1+DEBOUNCE_MS*(T1MS+1).
  - Release is symmetric, with L2H_Sig in place of H2L_Sig and Key_Release in place of Key_Press.
  - Key_Long is high LONG_MS*(T1MS+1) cycles after Key_Press.
- Simultaneous events:
  - In HELD, if L2H_Sig and the long-expiry tick coincide, L2H wins: go to RELEASE_WAIT, Key_Long not issued.
  - H2L_Sig and L2H_Sig both high: each state acts only on its own edge, the other is ignored.
- Pulses never overlap: Key_Press, Key_Release and Key_Long are mutually exclusive in any cycle.
- Key_State stays 1 through RELEASE_WAIT. It changes only together with the Key_Press/Key_Release pulses.
- Reset mid-operation (any state): immediate return to reset values. No pending pulse is emitted after RSTn releases.
- Widths: DEBOUNCE_MS and LONG_MS must each be ≥1 and ≤1023. LONG_MS is compared on the full 10 bits; no wrap because the counter saturates.

Test Plan:
(Bench params: T1MS=9, DEBOUNCE_MS=2, LONG_MS=5.)
1. Clean press: H2L_Sig pulse at cycle 100 -> Key_Press at cycle 121 only; Key_State 0->1 at 121; no other pulses.
2. Bounce rejection: H2L at 100, then L2H at 105, H2L at 110, L2H at 115 -> single Key_Press at 121; FSM stays HELD; no Key_Release.
3. Long press: press as in 1, hold -> Key_Long at cycle 171, exactly once. Keep holding 200 further cycles -> no second Key_Long.
4. Short press/release: press as in 1, L2H at 140 -> no Key_Long; Key_Release at 161; Key_State 1->0 at 161; FSM back to IDLE.
5. Race: press as in 1, L2H driven in the exact cycle the long tick would fire (cycle 170) -> Key_Long never asserts; Key_Release at 191.
6. Reset mid-operation: assert RSTn low at cycle 110 (during PRESS_WAIT) for 3 cycles -> all outputs 0, no Key_Press ever issued. A subsequent H2L at 200 -> Key_Press at 221.
